rtype_rf_sequencer: RTL and testbench

Multicycle R-type execution sequencer that acts as the initiator side of the CPU register file. It accepts one 32-bit MIPS R-type instruction through a valid/ready handshake and drives the two register-file read ports to fetch rs and rt. It computes the ALU result and issues a single-cycle write of rd back through the register-file write port. It sits between the instruction decode stage and the register file in the R_CPU datapath.

---
 rtl/rtype_rf_sequencer.sv | 174 +++++++++++++++++
 tb/tb_rtype_rf_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_rf_sequencer.sv
// ---------------------------------------------------------------------------
// rtype_rf_sequencer
//
// Multicycle MIPS R-type execution sequencer. It is the initiator side of the
// CPU register file. Each instruction goes through four states:
// IDLE -> FETCH -> EXEC -> WB -> IDLE.
// - FETCH: reads rs and rt through the two read ports.
// - EXEC:  computes the ALU result, overflow and legality.
// - WB:    issues a single-cycle write of rd.
// One instruction is accepted every four cycles.
//
// Parameters:
//   CHECK_OVF    1: signed overflow on add/sub suppresses the write and
//                   raises ovf.
//                0: add/sub behave exactly like addu/subu.
//
// Ports:
//   clka         rising-edge clock
//   rsta         asynchronous active-high reset
//   instr_valid  instruction offered by decode
//   instr_ready  high only while idle
//   instr        32-bit R-type instruction word
//   rf_raddra    read address A (rs)
//   rf_raddrb    read address B (rt)
//   rf_douta     read data A, combinational from rf_raddra
//   rf_doutb     read data B, combinational from rf_raddrb
//   rf_wea       write enable, high for one cycle per committed write
//   rf_waddra    write address (rd)
//   rf_dina      write data (ALU result)
//   done         one-cycle pulse when the instruction retires
//   ovf          one-cycle pulse with done on signed add/sub overflow
//   illegal      one-cycle pulse with done on unsupported op/funct
// ---------------------------------------------------------------------------
module rtype_rf_sequencer #(
   parameter bit CHECK_OVF = 1'b1
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [4:0]  rf_raddra,
   output logic [4:0]  rf_raddrb,
   input  logic [31:0] rf_douta,
   input  logic [31:0] rf_doutb,
   output logic        rf_wea,
   output logic [4:0]  rf_waddra,
   output logic [31:0] rf_dina,
   output logic        done,
   output logic        ovf,
   output logic        illegal
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

   state_t      state;

   // Only the fields still needed after FETCH are kept.
   // The read addresses are latched straight into the output registers.
   logic [5:0]  op_q;
   logic [4:0]  rd_q;
   logic [4:0]  shamt_q;
   logic [5:0]  funct_q;
   logic [31:0] op_a;
   logic [31:0] op_b;

   logic [31:0] alu_result;
   logic        alu_ovf;
   logic        alu_legal;
   logic [31:0] sum;
   logic [31:0] diff;

   // Ready is decoded from state alone.
   // Reset forces IDLE, so ready reads 1 while reset is held.
   assign instr_ready = (state == IDLE);

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   // ALU, legality and overflow detection on the captured operands.
   // Overflow compares the result sign with A:
   // - add overflows only when the operands share a sign,
   // - sub overflows only when the operand signs differ.
   always_comb begin
      alu_result = 32'd0;
      alu_ovf    = 1'b0;
      alu_legal  = (op_q == 6'd0);
      case (funct_q)
         6'h20: begin
            alu_result = sum;
            alu_ovf    = CHECK_OVF && (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
         end
         6'h21: alu_result = sum;
         6'h22: begin
            alu_result = diff;
            alu_ovf    = CHECK_OVF && (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
         end
         6'h23: alu_result = diff;
         6'h24: alu_result = op_a & op_b;
         6'h25: alu_result = op_a | op_b;
         6'h26: alu_result = op_a ^ op_b;
         6'h27: alu_result = ~(op_a | op_b);
         6'h2A: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
         6'h2B: alu_result = {31'd0, (op_a < op_b)};
         6'h00: alu_result = op_b << shamt_q;
         6'h02: alu_result = op_b >> shamt_q;
         6'h03: alu_result = $unsigned($signed(op_b) >>> shamt_q);
         default: alu_legal = 1'b0;
      endcase
   end

   // Main sequencer.
   // All outputs apart from instr_ready are registered here.
   // The retirement flags are loaded at the end of EXEC, so they are
   // visible for exactly the WB cycle.
   // Reset in any state drops the in-flight instruction before it can
   // write anything.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state     <= IDLE;
         op_q      <= 6'd0;
         rd_q      <= 5'd0;
         shamt_q   <= 5'd0;
         funct_q   <= 6'd0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         rf_raddra <= 5'd0;
         rf_raddrb <= 5'd0;
         rf_wea    <= 1'b0;
         rf_waddra <= 5'd0;
         rf_dina   <= 32'd0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q      <= instr[31:26];
                  rd_q      <= instr[15:11];
                  shamt_q   <= instr[10:6];
                  funct_q   <= instr[5:0];
                  rf_raddra <= instr[25:21];
                  rf_raddrb <= instr[20:16];
                  state     <= FETCH;
               end
            end
            FETCH: begin
               op_a  <= rf_douta;
               op_b  <= rf_doutb;
               state <= EXEC;
            end
            EXEC: begin
               rf_dina   <= alu_result;
               rf_waddra <= rd_q;
               rf_wea    <= alu_legal && !alu_ovf && (rd_q != 5'd0);
               done      <= 1'b1;
               ovf       <= alu_legal && alu_ovf;
               illegal   <= !alu_legal;
               state     <= WB;
            end
            WB: begin
               rf_wea  <= 1'b0;
               done    <= 1'b0;
               ovf     <= 1'b0;
               illegal <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtype_rf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rtype_rf_sequencer
//
// Drives rtype_rf_sequencer against a behavioural register file.
//
// Instances:
//   dut1   default configuration (overflow checking on).
//   dut2   CHECK_OVF = 0; used for the unchecked sub case only.
//
// Both instances read from the same register-file model.
//
// Checks:
//   - A table of instruction vectors is applied to dut1. Expected
//     retirement values are pushed onto a scoreboard queue when an
//     instruction is driven. They are popped and compared when done rises.
//   - Hand-written sequences cover exact cycle timing and a reset that
//     arrives mid-instruction.
// ---------------------------------------------------------------------------
module tb_rtype_rf_sequencer;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] a_val;
      logic [31:0] b_val;
      logic        exp_wea;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_data;
      logic        chk_data;
      logic        exp_ovf;
      logic        exp_ill;
   } vec_t;

   typedef struct {
      logic        wea;
      logic [4:0]  waddr;
      logic [31:0] data;
      logic        chk_data;
      logic        ovf;
      logic        ill;
   } exp_t;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        valid1 = 1'b0;
   logic        valid2 = 1'b0;

   logic        ready1, wea1, done1, ovf1, ill1;
   logic [4:0]  raddra1, raddrb1, waddr1;
   logic [31:0] douta1, doutb1, dina1;
   logic        ready2, wea2, done2, ovf2, ill2;
   logic [4:0]  raddra2, raddrb2, waddr2;
   logic [31:0] douta2, doutb2, dina2;

   logic [31:0] regs [32];
   logic        tb_we = 1'b0;
   logic [4:0]  tb_waddr = 5'd0;
   logic [31:0] tb_wdata = 32'd0;
   int          wea_count = 0;

   int          tests = 0;
   int          fails = 0;
   exp_t        sb [$];
   vec_t        vecs [17];

   always #5 clka = ~clka;

   rtype_rf_sequencer dut1 (
      .clka(clka), .rsta(rsta), .instr_valid(valid1), .instr_ready(ready1),
      .instr(instr), .rf_raddra(raddra1), .rf_raddrb(raddrb1),
      .rf_douta(douta1), .rf_doutb(doutb1), .rf_wea(wea1),
      .rf_waddra(waddr1), .rf_dina(dina1), .done(done1), .ovf(ovf1),
      .illegal(ill1)
   );

   rtype_rf_sequencer #(.CHECK_OVF(1'b0)) dut2 (
      .clka(clka), .rsta(rsta), .instr_valid(valid2), .instr_ready(ready2),
      .instr(instr), .rf_raddra(raddra2), .rf_raddrb(raddrb2),
      .rf_douta(douta2), .rf_doutb(doutb2), .rf_wea(wea2),
      .rf_waddra(waddr2), .rf_dina(dina2), .done(done2), .ovf(ovf2),
      .illegal(ill2)
   );

   // Register file model.
   // Reads are combinational, and R0 always reads zero.
   assign douta1 = (raddra1 == 5'd0) ? 32'd0 : regs[raddra1];
   assign doutb1 = (raddrb1 == 5'd0) ? 32'd0 : regs[raddrb1];
   assign douta2 = (raddra2 == 5'd0) ? 32'd0 : regs[raddra2];
   assign doutb2 = (raddrb2 == 5'd0) ? 32'd0 : regs[raddrb2];

   // Register file writes.
   // Bench preloads and DUT writes all go through this one process.
   always @(posedge clka) begin
      if (tb_we)
         regs[tb_waddr] <= tb_wdata;
      else if (wea1)
         regs[waddr1] <= dina1;
      else if (wea2)
         regs[waddr2] <= dina2;
      if (wea1)
         wea_count <= wea_count + 1;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic setReg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clka);
      tb_we    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      @(posedge clka);
      #1 tb_we = 1'b0;
   endtask

   // Offer one instruction to the selected instance and queue its
   // expected retirement.
   task automatic applyStimulus(input logic [31:0] word, input int which, input exp_t e);
      sb.push_back(e);
      @(negedge clka);
      cmp("ready_before_issue", (which == 2) ? {31'd0, ready2} : {31'd0, ready1}, 32'd1);
      instr = word;
      if (which == 2) valid2 = 1'b1; else valid1 = 1'b1;
      @(posedge clka);
      #1;
      valid1 = 1'b0;
      valid2 = 1'b0;
      instr  = 32'hFFFF_FFFF;
   endtask

   // Wait, with a bound, for retirement on the selected instance.
   // Then compare against the oldest scoreboard entry and confirm the
   // register file saw the write.
   task automatic checkOutput(input int which);
      exp_t e;
      logic seen;
      logic wea, dn, ov, il;
      logic [4:0]  wa;
      logic [31:0] wd;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clka);
         if ((which == 2) ? done2 : done1) begin
            seen = 1'b1;
            break;
         end
      end
      e = sb.pop_front();
      tests++;
      if (!seen) begin
         fails++;
         $display("[TB] FAIL done_timeout: got no done, expected done within 8 cycles");
         return;
      end
      wea = (which == 2) ? wea2 : wea1;
      dn  = (which == 2) ? done2 : done1;
      ov  = (which == 2) ? ovf2 : ovf1;
      il  = (which == 2) ? ill2 : ill1;
      wa  = (which == 2) ? waddr2 : waddr1;
      wd  = (which == 2) ? dina2 : dina1;
      cmp("done", {31'd0, dn}, 32'd1);
      cmp("rf_wea", {31'd0, wea}, {31'd0, e.wea});
      cmp("ovf", {31'd0, ov}, {31'd0, e.ovf});
      cmp("illegal", {31'd0, il}, {31'd0, e.ill});
      cmp("rf_waddra", {27'd0, wa}, {27'd0, e.waddr});
      if (e.chk_data)
         cmp("rf_dina", wd, e.data);
      @(posedge clka);
      #1;
      if (e.wea)
         cmp("regfile_written", regs[e.waddr], e.data);
      cmp("wea_cleared", (which == 2) ? {31'd0, wea2} : {31'd0, wea1}, 32'd0);
   endtask

   task automatic runVector(input vec_t v);
      exp_t e;
      if (v.instr[25:21] != 5'd0) setReg(v.instr[25:21], v.a_val);
      if (v.instr[20:16] != 5'd0) setReg(v.instr[20:16], v.b_val);
      e = '{v.exp_wea, v.exp_waddr, v.exp_data, v.chk_data, v.exp_ovf, v.exp_ill};
      applyStimulus(v.instr, 1, e);
      checkOutput(1);
   endtask

   initial begin
      exp_t e;
      int   wc;

      // Columns: instr, A, B, wea, rd, data, check data, ovf, illegal.
      vecs[0]  = '{32'h00221820, 32'd5,        32'd7,        1'b1, 5'd3,  32'd12,       1'b1, 1'b0, 1'b0};
      vecs[1]  = '{32'h00222022, 32'h80000000, 32'd1,        1'b0, 5'd4,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{32'h0022282A, 32'hFFFFFFFF, 32'd1,        1'b1, 5'd5,  32'd1,        1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'h0022282B, 32'hFFFFFFFF, 32'd1,        1'b1, 5'd5,  32'd0,        1'b1, 1'b0, 1'b0};
      vecs[4]  = '{32'h00023103, 32'd0,        32'h80000000, 1'b1, 5'd6,  32'hF8000000, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'h20220001, 32'd5,        32'd7,        1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1};
      vecs[6]  = '{32'h00220020, 32'd5,        32'd7,        1'b0, 5'd0,  32'd12,       1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'h00223824, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd7,  32'hF000F000, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{32'h00224025, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd8,  32'hFFF0FFF0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{32'h00224826, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd9,  32'h0FF00FF0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'h00225027, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd10, 32'h000F000F, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{32'h00025A00, 32'd0,        32'h12345678, 1'b1, 5'd11, 32'h34567800, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{32'h00026102, 32'd0,        32'h80000000, 1'b1, 5'd12, 32'h08000000, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{32'h00226821, 32'h7FFFFFFF, 32'd1,        1'b1, 5'd13, 32'h80000000, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{32'h00227020, 32'h7FFFFFFF, 32'd1,        1'b0, 5'd14, 32'h80000000, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{32'h00227823, 32'd3,        32'd5,        1'b1, 5'd15, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{32'h00228001, 32'd5,        32'd7,        1'b0, 5'd16, 32'd0,        1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 32; i++) regs[i] = 32'd0;

      // Reset state while rsta is held.
      #12;
      cmp("reset_ready", {31'd0, ready1}, 32'd1);
      cmp("reset_wea", {31'd0, wea1}, 32'd0);
      cmp("reset_done", {31'd0, done1}, 32'd0);
      cmp("reset_raddra", {27'd0, raddra1}, 32'd0);
      cmp("reset_dina", dina1, 32'd0);
      @(negedge clka);
      rsta = 1'b0;

      // Exact cycle timing of a plain add.
      setReg(5'd1, 32'd5);
      setReg(5'd2, 32'd7);
      @(negedge clka);
      instr  = 32'h00221820;
      valid1 = 1'b1;
      @(posedge clka);
      #1 valid1 = 1'b0;
      instr = 32'h0;
      cmp("fetch_ready_low", {31'd0, ready1}, 32'd0);
      cmp("fetch_raddra", {27'd0, raddra1}, 32'd1);
      cmp("fetch_raddrb", {27'd0, raddrb1}, 32'd2);
      @(posedge clka);
      #1 cmp("exec_wea_low", {31'd0, wea1}, 32'd0);
      @(posedge clka);
      #1;
      cmp("wb_wea", {31'd0, wea1}, 32'd1);
      cmp("wb_waddra", {27'd0, waddr1}, 32'd3);
      cmp("wb_dina", dina1, 32'd12);
      cmp("wb_done", {31'd0, done1}, 32'd1);
      @(posedge clka);
      #1;
      cmp("post_wb_ready", {31'd0, ready1}, 32'd1);
      cmp("post_wb_done", {31'd0, done1}, 32'd0);
      cmp("post_wb_reg3", regs[3], 32'd12);

      // Table-driven vectors through the scoreboard.
      foreach (vecs[i]) runVector(vecs[i]);

      // Unchecked sub on the CHECK_OVF = 0 instance.
      setReg(5'd1, 32'h80000000);
      setReg(5'd2, 32'd1);
      e = '{1'b1, 5'd4, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
      applyStimulus(32'h00222022, 2, e);
      checkOutput(2);

      // Reset arriving during EXEC must abort the add without a write.
      setReg(5'd1, 32'd5);
      setReg(5'd2, 32'd7);
      setReg(5'd3, 32'hDEADBEEF);
      @(negedge clka);
      wc     = wea_count;
      instr  = 32'h00221820;
      valid1 = 1'b1;
      @(posedge clka);
      #1 valid1 = 1'b0;
      @(posedge clka);
      @(negedge clka);
      rsta = 1'b1;
      #1;
      cmp("rst_mid_ready", {31'd0, ready1}, 32'd1);
      cmp("rst_mid_raddra", {27'd0, raddra1}, 32'd0);
      cmp("rst_mid_raddrb", {27'd0, raddrb1}, 32'd0);
      cmp("rst_mid_wea", {31'd0, wea1}, 32'd0);
      cmp("rst_mid_waddra", {27'd0, waddr1}, 32'd0);
      cmp("rst_mid_dina", dina1, 32'd0);
      cmp("rst_mid_flags", {29'd0, done1, ovf1, ill1}, 32'd0);
      @(posedge clka);
      @(negedge clka);
      rsta = 1'b0;
      repeat (4) @(negedge clka);
      cmp("rst_no_write", wea_count - wc, 32'd0);
      cmp("rst_reg3_kept", regs[3], 32'hDEADBEEF);
      cmp("rst_after_ready", {31'd0, ready1}, 32'd1);
      runVector(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
